// File: rtl/bitserial_core_p_if.sv
// Instruction handshake and status bundle for bitserial_core_p.
// The master drives instructions and the slave (the core) reports status.
interface bitserial_core_p_if #(
  parameter int WIDTH = 8
);
  logic             instr_valid;
  logic             instr_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] imm;
  logic [3:0]       rsel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] acc_out;
  logic [WIDTH-1:0] out_result;
  logic             flag_z;
  logic             flag_c;

  modport master (
    output instr_valid, opcode, imm, rsel,
    input  instr_ready, busy, done, acc_out, out_result, flag_z, flag_c
  );

  modport slave (
    input  instr_valid, opcode, imm, rsel,
    output instr_ready, busy, done, acc_out, out_result, flag_z, flag_c
  );
endinterface

// File: rtl/bitserial_core_p.sv
// Bit-serial accumulator core: ALU ops run LSB-first over WIDTH cycles.
// Optional zero/carry flags are built when BITSERIAL_FLAGS_EN is defined.
module bitserial_core_p #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input logic               clk,
  input logic               rst,
  bitserial_core_p_if.slave s_bus
);
  localparam int RSEL_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int CNT_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [3:0] OP_LDI = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd8;
  localparam logic [3:0] OP_ST  = 4'd14;
  localparam logic [3:0] OP_OUT = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [2:0]       r_alu;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_regs [NREGS];

  logic             w_accept;
  logic             w_is_alu;
  logic             w_rsel_ok;
  logic             w_last;
  logic [WIDTH-1:0] w_reg_rd;
  logic [WIDTH-1:0] w_opnd;
  logic             w_b;
  logic             w_bit;
  logic             w_cout;
  logic [WIDTH-1:0] w_acc_shifted;

  assign w_accept  = s_bus.instr_valid && (r_state == S_IDLE);
  // Opcodes 1-5 and 9-13 share low bits 1..5; every ALU op is decoded from those.
  assign w_is_alu  = (s_bus.opcode[2:0] >= 3'd1) && (s_bus.opcode[2:0] <= 3'd5);
  assign w_rsel_ok = ({1'b0, s_bus.rsel} < 5'(NREGS));
  assign w_reg_rd  = w_rsel_ok ? r_regs[s_bus.rsel[RSEL_W-1:0]] : '0;
  assign w_opnd    = s_bus.opcode[3] ? w_reg_rd : s_bus.imm;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  // One result bit per cycle from the LSBs of the (right-shifting) acc and operand.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_b    = (r_alu == ALU_SUB) ? ~r_opnd[0] : r_opnd[0];
    w_bit  = r_acc[0] ^ w_b;
    w_cout = r_carry;
    case (r_alu)
      ALU_ADD, ALU_SUB: begin
        w_bit  = r_acc[0] ^ w_b ^ r_carry;
        w_cout = (r_acc[0] & w_b) | (r_carry & (r_acc[0] ^ w_b));
      end
      ALU_AND: w_bit = r_acc[0] & w_b;
      ALU_OR:  w_bit = r_acc[0] | w_b;
      default: w_bit = r_acc[0] ^ w_b;
    endcase
  end

  assign w_acc_shifted = {w_bit, r_acc[WIDTH-1:1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_is_alu ? S_SHIFT : S_DONE;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_alu   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_out   <= '0;
      // NOTE: the register file must read 0 after reset, so it is cleared here.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_opnd  <= w_opnd;
            r_alu   <= s_bus.opcode[2:0];
            r_carry <= (s_bus.opcode[2:0] == ALU_SUB);
            r_cnt   <= '0;
            case (s_bus.opcode)
              OP_LDI: r_acc <= s_bus.imm;
              OP_LD:  r_acc <= w_reg_rd;
              OP_ST:  if (w_rsel_ok) r_regs[s_bus.rsel[RSEL_W-1:0]] <= r_acc;
              OP_OUT: r_out <= r_acc;
              default: ;
            endcase
          end
        end
        S_SHIFT: begin
          r_acc   <= w_acc_shifted;
          r_opnd  <= r_opnd >> 1;
          r_carry <= w_cout;
          r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef BITSERIAL_FLAGS_EN
  logic r_flag_z;
  logic r_flag_c;

  // Flags land on the edge into DONE, so they are valid together with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else if (w_accept && (s_bus.opcode == OP_LDI || s_bus.opcode == OP_LD)) begin
      r_flag_z <= (s_bus.opcode[3] ? w_reg_rd : s_bus.imm) == '0;
    end else if (r_state == S_SHIFT && w_last) begin
      r_flag_z <= (w_acc_shifted == '0);
      if (r_alu == ALU_ADD || r_alu == ALU_SUB) r_flag_c <= w_cout;
    end
  end

  assign s_bus.flag_z = r_flag_z;
  assign s_bus.flag_c = r_flag_c;
`else
  assign s_bus.flag_z = 1'b0;
  assign s_bus.flag_c = 1'b0;
`endif

  assign s_bus.instr_ready = (r_state == S_IDLE);
  assign s_bus.busy        = (r_state != S_IDLE);
  assign s_bus.done        = (r_state == S_DONE);
  assign s_bus.acc_out     = r_acc;
  assign s_bus.out_result  = r_out;
endmodule

// File: tb/tb_bitserial_core_p.sv
// Directed testbench for bitserial_core_p: 8-bit and 16-bit instances side by side.
// Flag expectations follow whether BITSERIAL_FLAGS_EN is defined for the build.
module tb_bitserial_core_p;
`ifdef BITSERIAL_FLAGS_EN
  localparam bit FLG = 1'b1;
`else
  localparam bit FLG = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bitserial_core_p_if #(.WIDTH(8))  bus8 ();
  bitserial_core_p_if #(.WIDTH(16)) bus16 ();

  bitserial_core_p #(.WIDTH(8), .NREGS(4)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus8)
  );

  bitserial_core_p #(.WIDTH(16), .NREGS(4)) dut16 (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Issue one instruction, then wait (bounded) for done; lat counts cycles from accept.
  task automatic exec(input bit wide, input logic [3:0] op, input logic [15:0] imm,
                      input logic [3:0] rs, output int lat);
    @(posedge clk); #1;
    if (wide) begin
      bus16.instr_valid = 1'b1; bus16.opcode = op; bus16.imm = imm; bus16.rsel = rs;
    end else begin
      bus8.instr_valid = 1'b1; bus8.opcode = op; bus8.imm = imm[7:0]; bus8.rsel = rs;
    end
    @(posedge clk); #1;
    bus8.instr_valid  = 1'b0;
    bus16.instr_valid = 1'b0;
    lat = 1;
    while (!(wide ? bus16.done : bus8.done) && lat <= 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat > 40) begin
      checks++; errors++;
      $display("FAIL timeout: opcode %0d gave no done after %0d cycles", op, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus8.acc_out !== 8'h00 || bus8.out_result !== 8'h00 || bus8.done !== 1'b0 ||
        bus8.flag_z !== 1'b0 || bus8.flag_c !== 1'b0 || bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset8: acc=%h out=%h done=%b z=%b c=%b busy=%b, want all 0",
               bus8.acc_out, bus8.out_result, bus8.done, bus8.flag_z, bus8.flag_c, bus8.busy);
    end
    checks++;
    if (bus16.acc_out !== 16'h0000 || bus16.done !== 1'b0 || bus16.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset16: acc=%h done=%b busy=%b, want 0", bus16.acc_out, bus16.done, bus16.busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus8.instr_ready !== 1'b1 || bus16.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b/%b want 1/1", bus8.instr_ready, bus16.instr_ready);
    end
  endtask

  task automatic test_addi();
    int lat;
    exec(1'b0, 4'd0, 16'h005A, 4'd0, lat);
    checks++;
    if (lat != 1 || bus8.acc_out !== 8'h5A) begin
      errors++;
      $display("FAIL ldi: lat=%0d acc=%h want lat=1 acc=5a", lat, bus8.acc_out);
    end
    exec(1'b0, 4'd1, 16'h00C3, 4'd0, lat);
    checks++;
    if (lat != 9) begin
      errors++;
      $display("FAIL addi_latency: got %0d want 9", lat);
    end
    checks++;
    if (bus8.acc_out !== 8'h1D || bus8.flag_c !== FLG || bus8.flag_z !== 1'b0) begin
      errors++;
      $display("FAIL addi: acc=%h c=%b z=%b want acc=1d c=%b z=0",
               bus8.acc_out, bus8.flag_c, bus8.flag_z, FLG);
    end
  endtask

  task automatic test_subi();
    int lat;
    exec(1'b0, 4'd0, 16'h0010, 4'd0, lat);
    exec(1'b0, 4'd2, 16'h0011, 4'd0, lat);
    checks++;
    if (bus8.acc_out !== 8'hFF || bus8.flag_c !== 1'b0 || bus8.flag_z !== 1'b0) begin
      errors++;
      $display("FAIL subi_borrow: acc=%h c=%b z=%b want acc=ff c=0 z=0",
               bus8.acc_out, bus8.flag_c, bus8.flag_z);
    end
    exec(1'b0, 4'd2, 16'h00FF, 4'd0, lat);
    checks++;
    if (bus8.acc_out !== 8'h00 || bus8.flag_c !== FLG || bus8.flag_z !== FLG) begin
      errors++;
      $display("FAIL subi_zero: acc=%h c=%b z=%b want acc=00 c=%b z=%b",
               bus8.acc_out, bus8.flag_c, bus8.flag_z, FLG, FLG);
    end
  endtask

  task automatic test_regs();
    int lat;
    exec(1'b0, 4'd0, 16'h003C, 4'd0, lat);
    exec(1'b0, 4'd14, 16'h0000, 4'd2, lat);
    exec(1'b0, 4'd0, 16'h000F, 4'd0, lat);
    exec(1'b0, 4'd11, 16'h0000, 4'd2, lat);
    checks++;
    if (bus8.acc_out !== 8'h0C || bus8.flag_c !== FLG || bus8.flag_z !== 1'b0) begin
      errors++;
      $display("FAIL and_reg: acc=%h c=%b z=%b want acc=0c c=%b (kept) z=0",
               bus8.acc_out, bus8.flag_c, bus8.flag_z, FLG);
    end
    exec(1'b0, 4'd14, 16'h0000, 4'd5, lat);
    exec(1'b0, 4'd8, 16'h0000, 4'd5, lat);
    checks++;
    if (bus8.acc_out !== 8'h00 || bus8.flag_z !== FLG) begin
      errors++;
      $display("FAIL ld_out_of_range: acc=%h z=%b want acc=00 z=%b", bus8.acc_out, bus8.flag_z, FLG);
    end
    exec(1'b0, 4'd8, 16'h0000, 4'd2, lat);
    checks++;
    if (bus8.acc_out !== 8'h3C) begin
      errors++;
      $display("FAIL ld_r2: got %h want 3c", bus8.acc_out);
    end
  endtask

  task automatic test_out_busy();
    int lat;
    int bad_ready;
    exec(1'b0, 4'd0, 16'h00A5, 4'd0, lat);
    exec(1'b0, 4'd15, 16'h0000, 4'd0, lat);
    checks++;
    if (lat != 1 || bus8.out_result !== 8'hA5) begin
      errors++;
      $display("FAIL out: lat=%0d out=%h want lat=1 out=a5", lat, bus8.out_result);
    end
    // ADDI 0x01 with instr_valid held high (presenting LDI 0x77) for the whole SHIFT phase
    @(posedge clk); #1;
    bus8.instr_valid = 1'b1; bus8.opcode = 4'd1; bus8.imm = 8'h01; bus8.rsel = 4'd0;
    @(posedge clk); #1;
    bus8.opcode = 4'd0; bus8.imm = 8'h77;
    bad_ready = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus8.instr_ready !== 1'b0 || bus8.busy !== 1'b1) bad_ready++;
      if (i == 1) begin
        checks++;
        if (bus8.acc_out !== 8'h52) begin
          errors++;
          $display("FAIL partial_acc: got %h want 52", bus8.acc_out);
        end
      end
      @(posedge clk); #1;
    end
    bus8.instr_valid = 1'b0;
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL ready_in_shift: %0d shift cycles had ready=1 or busy=0, want 0", bad_ready);
    end
    checks++;
    if (bus8.done !== 1'b1 || bus8.acc_out !== 8'hA6 || bus8.out_result !== 8'hA5) begin
      errors++;
      $display("FAIL held_valid: done=%b acc=%h out=%h want done=1 acc=a6 out=a5",
               bus8.done, bus8.acc_out, bus8.out_result);
    end
    @(posedge clk); #1;
    checks++;
    if (bus8.acc_out !== 8'hA6 || bus8.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_accept_in_shift: acc=%h ready=%b want acc=a6 ready=1",
               bus8.acc_out, bus8.instr_ready);
    end
  endtask

  task automatic test_nop();
    int lat;
    exec(1'b0, 4'd6, 16'h0033, 4'd0, lat);
    checks++;
    if (lat != 1 || bus8.acc_out !== 8'hA6) begin
      errors++;
      $display("FAIL nop6: lat=%0d acc=%h want lat=1 acc=a6", lat, bus8.acc_out);
    end
    exec(1'b0, 4'd7, 16'h0033, 4'd0, lat);
    checks++;
    if (lat != 1 || bus8.acc_out !== 8'hA6) begin
      errors++;
      $display("FAIL nop7: lat=%0d acc=%h want lat=1 acc=a6", lat, bus8.acc_out);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    exec(1'b0, 4'd0, 16'h0020, 4'd0, lat);
    exec(1'b0, 4'd14, 16'h0000, 4'd1, lat);
    exec(1'b0, 4'd0, 16'h0005, 4'd0, lat);
    exec(1'b0, 4'd10, 16'h0000, 4'd1, lat);
    checks++;
    if (lat != 9 || bus8.acc_out !== 8'hE5 || bus8.flag_c !== 1'b0) begin
      errors++;
      $display("FAIL sub_reg: lat=%0d acc=%h c=%b want lat=9 acc=e5 c=0", lat, bus8.acc_out, bus8.flag_c);
    end
    exec(1'b0, 4'd5, 16'h00FF, 4'd0, lat);
    checks++;
    if (bus8.acc_out !== 8'h1A) begin
      errors++;
      $display("FAIL xori: got %h want 1a", bus8.acc_out);
    end
    exec(1'b0, 4'd4, 16'h0040, 4'd0, lat);
    checks++;
    if (bus8.acc_out !== 8'h5A) begin
      errors++;
      $display("FAIL ori: got %h want 5a", bus8.acc_out);
    end
    exec(1'b0, 4'd9, 16'h0000, 4'd1, lat);
    checks++;
    if (bus8.acc_out !== 8'h7A || bus8.flag_c !== 1'b0) begin
      errors++;
      $display("FAIL add_reg: acc=%h c=%b want acc=7a c=0", bus8.acc_out, bus8.flag_c);
    end
    exec(1'b0, 4'd3, 16'h000F, 4'd0, lat);
    checks++;
    if (bus8.acc_out !== 8'h0A) begin
      errors++;
      $display("FAIL andi: got %h want 0a", bus8.acc_out);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    exec(1'b0, 4'd0, 16'h00FF, 4'd0, lat);
    exec(1'b0, 4'd1, 16'h0001, 4'd0, lat);
    exec(1'b0, 4'd0, 16'h0044, 4'd0, lat);
    exec(1'b0, 4'd15, 16'h0000, 4'd0, lat);
    checks++;
    if (bus8.out_result !== 8'h44 || bus8.flag_c !== FLG) begin
      errors++;
      $display("FAIL pre_abort: out=%h c=%b want out=44 c=%b", bus8.out_result, bus8.flag_c, FLG);
    end
    @(posedge clk); #1;
    bus8.instr_valid = 1'b1; bus8.opcode = 4'd1; bus8.imm = 8'h11; bus8.rsel = 4'd0;
    @(posedge clk); #1;
    bus8.instr_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus8.busy !== 1'b0 || bus8.acc_out !== 8'h00 || bus8.out_result !== 8'h00 ||
        bus8.flag_z !== 1'b0 || bus8.flag_c !== 1'b0 || bus8.done !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy=%b acc=%h out=%h z=%b c=%b done=%b want all 0",
               bus8.busy, bus8.acc_out, bus8.out_result, bus8.flag_z, bus8.flag_c, bus8.done);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus8.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: got %b want 1", bus8.instr_ready);
    end
    exec(1'b0, 4'd8, 16'h0000, 4'd2, lat);
    checks++;
    if (bus8.acc_out !== 8'h00) begin
      errors++;
      $display("FAIL regs_cleared: r2 read %h want 00", bus8.acc_out);
    end
  endtask

  task automatic test_wide();
    int lat;
    exec(1'b1, 4'd0, 16'hFFFF, 4'd0, lat);
    exec(1'b1, 4'd1, 16'h0001, 4'd0, lat);
    checks++;
    if (lat != 17) begin
      errors++;
      $display("FAIL wide_latency: got %0d want 17", lat);
    end
    checks++;
    if (bus16.acc_out !== 16'h0000 || bus16.flag_c !== FLG || bus16.flag_z !== FLG) begin
      errors++;
      $display("FAIL wide_addi: acc=%h c=%b z=%b want acc=0000 c=%b z=%b",
               bus16.acc_out, bus16.flag_c, bus16.flag_z, FLG, FLG);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus8.instr_valid  = 1'b0; bus8.opcode  = '0; bus8.imm  = '0; bus8.rsel  = '0;
    bus16.instr_valid = 1'b0; bus16.opcode = '0; bus16.imm = '0; bus16.rsel = '0;
    test_reset();
    test_addi();
    test_subi();
    test_regs();
    test_out_busy();
    test_nop();
    test_back_to_back();
    test_reset_abort();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bitserial_core_p.md
BITSERIAL_CORE_P -- requirements
Module: bitserial_core_p

Interface
REQ-001 SHALL have parameter WIDTH, default 8: datapath, accumulator, register and immediate width (legal 4..32).
REQ-002 SHALL have parameter NREGS, default 4: register-file depth (legal 2..16); RSEL_W = clog2(NREGS).
REQ-003 SHALL have ports:
- clk, input, 1: sole clock; every flop updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- instr_valid, input, 1: an instruction is presented.
- instr_ready, output, 1: core can accept an instruction.
- opcode, input, 4: operation code.
- imm, input, WIDTH: immediate operand.
- rsel, input, 4: register index.
- busy, output, 1: an instruction is executing.
- done, output, 1: one-cycle pulse when an instruction retires.
- acc_out, output, WIDTH: current accumulator.
- out_result, output, WIDTH: value latched by OUT.
- flag_z, output, 1: zero flag.
- flag_c, output, 1: carry flag.

Function
REQ-004 An instruction SHALL be accepted only on a cycle with instr_valid=1 and instr_ready=1; opcode, imm and rsel SHALL be captured on that cycle.
REQ-005 instr_ready SHALL equal 1 only in IDLE; busy SHALL equal NOT instr_ready; instr_valid outside IDLE SHALL be ignored.
REQ-006 Opcodes SHALL be:
- 0 LDI, 1 ADDI, 2 SUBI, 3 ANDI, 4 ORI, 5 XORI: second operand is imm.
- 8 LD, 9 ADD, 10 SUB, 11 AND, 12 OR, 13 XOR: second operand is reg[rsel].
- 14 ST: reg[rsel] <= acc.
- 15 OUT: out_result <= acc.
- 6, 7: NOP.
REQ-007 FSM states SHALL be IDLE, SHIFT, DONE. From IDLE, an accepted ALU op (1-5, 9-13) SHALL go to SHIFT. Every other accepted op SHALL go straight to DONE and take effect at that transition.
REQ-008 SHIFT SHALL last exactly WIDTH cycles and process one bit per cycle, LSB first, with bit counter 0..WIDTH-1. On the last bit the counter SHALL wrap to 0 and the FSM SHALL go to DONE.
REQ-009 Result bits SHALL be shifted into the accumulator MSB-first-in, so the full result is in acc after the last SHIFT cycle. Each bit SHALL be computed from the original acc value.
REQ-010 ADD SHALL be serial full-add with carry flop initialised to 0. SUB SHALL be acc + ~op with carry flop initialised to 1. Results SHALL wrap modulo 2^WIDTH.
REQ-011 DONE SHALL last 1 cycle, assert done=1, and return to IDLE. ALU-op latency from acceptance to done is WIDTH+1 cycles; all other ops take 1 cycle.
REQ-012 rsel >= NREGS SHALL read as 0, and ST to such an index SHALL be dropped.
REQ-013 acc_out SHALL show the accumulator continuously, including partial values during SHIFT.

Reset
REQ-014 While rst=1 the core SHALL force the following on the next edge, aborting any instruction in progress:
- FSM=IDLE, bit counter=0, carry flop=0
- acc=0, all registers=0, out_result=0
- done=0, flag_z=0, flag_c=0
REQ-015 instr_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-016 With macro BITSERIAL_FLAGS_EN defined:
- flag_z SHALL update in DONE after every op that writes acc (LDI, LD, ALU ops), set to (acc==0).
- flag_c SHALL update in DONE after ADD/ADDI/SUB/SUBI, set to the final carry out (SUB: 1 = no borrow).
- Other ops SHALL leave both flags unchanged.
REQ-017 Without BITSERIAL_FLAGS_EN, flag_z and flag_c SHALL be constant 0 and no flag flops SHALL be built.

Verification (WIDTH=8, NREGS=4, flags enabled)
REQ-018 LDI 0x5A, then ADDI 0xC3 -> acc=0x1D, flag_c=1, flag_z=0; done exactly 9 cycles after the ADDI accept.
REQ-019 LDI 0x10, then SUBI 0x11 -> acc=0xFF, flag_c=0; then SUBI 0xFF -> acc=0x00, flag_z=1, flag_c=1.
REQ-020 LDI 0x3C, ST r2, LDI 0x0F, AND r2 -> acc=0x0C; ST r5 is dropped and LD r5 gives acc=0x00.
REQ-021 LDI 0xA5, OUT -> out_result=0xA5 one cycle after accept; instr_valid held high during SHIFT is not accepted and instr_ready=0 throughout.
REQ-022 rst=1 on the 4th SHIFT cycle of ADDI -> next cycle: FSM=IDLE, acc=0, out_result=0, flags=0, instr_ready=1 after rst falls.
REQ-023 WIDTH=16 build: ADDI 0x0001 on acc=0xFFFF -> acc=0x0000, flag_c=1, flag_z=1, done 17 cycles after accept.
